m_a_selftest_ctrl: RTL



---
 rtl/m_a_selftest_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/m_a_selftest_ctrl.sv
// Built-in self-test sequencer for the combinational block m_a.
// Walks {x1,x2,x3} through codes 0..7, waits SETTLE cycles per code, samples
// z1/z2, compares against the expected truth tables and reports the results.
module m_a_selftest_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter logic [7:0]  EXP_Z1 = 8'hB6,
  parameter logic [7:0]  EXP_Z2 = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       z1,
  input  logic       z2,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] z1_vec,
  output logic [7:0] z2_vec,
  output logic [7:0] err_mask,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [3:0] scnt;
  logic       settle_end;
  logic       mism;

  // Settle expiry and 4-state comparison of the current sample
  always_comb begin
    settle_end = (scnt == SETTLE_LAST);
    mism       = (z1 !== EXP_Z1[idx]) || (z2 !== EXP_Z2[idx]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start wins over abort in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)           state_nxt = S_IDLE;
        else if (settle_end) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)            state_nxt = S_IDLE;
        else if (idx == 3'd7) state_nxt = S_DONE;
        else                  state_nxt = S_SETTLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state; stimulus always mirrors idx
  always_comb begin
    {x1, x2, x3} = idx;
    busy         = (state == S_SETTLE) || (state == S_SAMPLE);
    done         = (state == S_DONE);
  end

  // Datapath: counters, capture and result accumulation
  // pass is resolved on the final sample edge (folding in that sample's
  // mismatch) so it is already valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      scnt       <= '0;
      pass       <= 1'b0;
      z1_vec     <= '0;
      z2_vec     <= '0;
      err_mask   <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx        <= '0;
            scnt       <= '0;
            pass       <= 1'b0;
            z1_vec     <= '0;
            z2_vec     <= '0;
            err_mask   <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            idx  <= '0;
            scnt <= '0;
            pass <= 1'b0;
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            idx  <= '0;
            scnt <= '0;
            pass <= 1'b0;
          end else begin
            z1_vec[idx] <= z1;
            z2_vec[idx] <= z2;
            if (mism) begin
              err_mask[idx] <= 1'b1;
              err_cnt       <= err_cnt + 4'd1;
              if (err_cnt == 4'd0) first_fail <= idx;
            end
            scnt <= '0;
            if (idx == 3'd7) begin
              idx  <= '0;
              pass <= (err_cnt == 4'd0) && !mism;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
